// File: rtl/lr_d_sequencer_pkg.sv
// Shared types and widths for the leaky-ReLU-derivative row sequencer.
package lr_d_sequencer_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lr_d_skew_line.sv
// Fixed-depth delay for one column's valid/gradient/H triple (DEPTH >= 1).
module lr_d_skew_line
  import lr_d_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_g,
  input  logic [W-1:0] i_h,
  output logic         o_vld,
  output logic [W-1:0] o_g,
  output logic [W-1:0] o_h
);

  logic [DEPTH-1:0]        r_vld;
  logic [DEPTH-1:0][W-1:0] r_g;
  logic [DEPTH-1:0][W-1:0] r_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_g   <= '0;
      r_h   <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_g[0]   <= i_g;
      r_h[0]   <= i_h;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_vld[k] <= r_vld[k-1];
        r_g[k]   <= r_g[k-1];
        r_h[k]   <= r_h[k-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_g   = r_g[DEPTH-1];
  assign o_h   = r_h[DEPTH-1];

endmodule

// File: rtl/lr_d_sequencer.sv
// Streams buffer rows into the leaky-ReLU-derivative datapath with a diagonal
// column skew and writes each column's results back to a linear buffer region.
module lr_d_sequencer
  import lr_d_sequencer_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CHILD_LAT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               cfg_rows,
  input  logic [ADDR_W-1:0]               cfg_base_g,
  input  logic [ADDR_W-1:0]               cfg_base_h,
  input  logic [ADDR_W-1:0]               cfg_base_wr,
  input  logic signed [DATA_W-1:0]        cfg_leak,
  input  logic                            pause,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [ADDR_W-1:0]               rd_addr_g,
  output logic [ADDR_W-1:0]               rd_addr_h,
  input  logic [N-1:0][DATA_W-1:0]        rd_data_g,
  input  logic [N-1:0][DATA_W-1:0]        rd_data_h,
  output logic [N-1:0]                    lr_d_valid_in,
  output logic [N-1:0][DATA_W-1:0]        lr_d_data_in,
  output logic [N-1:0][DATA_W-1:0]        lr_d_H_in,
  output logic signed [DATA_W-1:0]        lr_leak_factor_out,
  input  logic [N-1:0]                    lr_d_valid_out,
  input  logic [N-1:0][DATA_W-1:0]        lr_d_data_out,
  output logic [N-1:0]                    wr_en,
  output logic [N-1:0][ADDR_W-1:0]        wr_addr,
  output logic [N-1:0][DATA_W-1:0]        wr_data
);

  if (CHILD_LAT < 1) begin : g_lat_chk
    $error("lr_d_sequencer: CHILD_LAT must be at least 1");
  end

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [ADDR_W-1:0]        r_rows;
  logic [ADDR_W-1:0]        r_base_g;
  logic [ADDR_W-1:0]        r_base_h;
  logic [ADDR_W-1:0]        r_base_wr;
  logic signed [DATA_W-1:0] r_leak;
  logic [ADDR_W-1:0]        r_row;
  logic                     r_rd_vld;
  logic [N-1:0][ADDR_W-1:0] r_wcnt;

  logic                     w_accept;
  logic                     w_issue;
  logic                     w_last_row;
  logic                     w_active;
  logic                     w_all_written;
  logic [N-1:0]             w_wr_en;
  logic [N-1:0][DATA_W-1:0] w_col_g;
  logic [N-1:0][DATA_W-1:0] w_col_h;

  // Next state and output decode; completion counts this cycle's writes so
  // done follows the final write-back by exactly one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = (r_state == IDLE) && start;
    w_issue       = (r_state == ISSUE) && !pause;
    w_last_row    = (r_row == ADDR_W'(r_rows - ADDR_W'(1)));
    w_active      = (r_state == ISSUE) || (r_state == DRAIN);
    w_wr_en       = lr_d_valid_out & {N{w_active}};
    w_all_written = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (ADDR_W'(r_wcnt[i] + ADDR_W'(w_wr_en[i])) != r_rows) begin
        w_all_written = 1'b0;
      end
    end

    busy      = w_active;
    done      = (r_state == DONE);
    rd_en     = w_issue;
    rd_addr_g = w_issue ? ADDR_W'(r_base_g + r_row) : '0;
    rd_addr_h = w_issue ? ADDR_W'(r_base_h + r_row) : '0;
    wr_en     = w_wr_en;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_wr_en[i]) begin
        wr_addr[i] = ADDR_W'(r_base_wr + r_wcnt[i]);
        wr_data[i] = lr_d_data_out[i];
      end
    end

    case (r_state)
      IDLE:    if (start) w_state_nxt = (cfg_rows == '0) ? DONE : ISSUE;
      ISSUE:   if (w_issue && w_last_row) w_state_nxt = DRAIN;
      DRAIN:   if (w_all_written) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rows    <= '0;
      r_base_g  <= '0;
      r_base_h  <= '0;
      r_base_wr <= '0;
      r_leak    <= '0;
      r_row     <= '0;
      r_rd_vld  <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= w_issue;
      if (w_accept) begin
        r_rows    <= cfg_rows;
        r_base_g  <= cfg_base_g;
        r_base_h  <= cfg_base_h;
        r_base_wr <= cfg_base_wr;
        r_leak    <= cfg_leak;
        r_row     <= '0;
        r_wcnt    <= '0;
      end else begin
        if (w_issue) r_row <= ADDR_W'(r_row + ADDR_W'(1));
        for (int i = 0; i < int'(N); i++) begin
          if (w_wr_en[i]) r_wcnt[i] <= ADDR_W'(r_wcnt[i] + ADDR_W'(1));
        end
      end
    end
  end

  // Returned row data is zeroed when no read was issued the cycle before.
  always_comb begin
    w_col_g = '0;
    w_col_h = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_rd_vld) begin
        w_col_g[i] = rd_data_g[i];
        w_col_h[i] = rd_data_h[i];
      end
    end
  end

  assign lr_d_valid_in[0]   = r_rd_vld;
  assign lr_d_data_in[0]    = w_col_g[0];
  assign lr_d_H_in[0]       = w_col_h[0];
  assign lr_leak_factor_out = r_leak;

  for (genvar i = 1; i < int'(N); i++) begin : g_skew
    lr_d_skew_line #(
      .DEPTH(i),
      .W    (DATA_W)
    ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .i_vld(r_rd_vld),
      .i_g  (w_col_g[i]),
      .i_h  (w_col_h[i]),
      .o_vld(lr_d_valid_in[i]),
      .o_g  (lr_d_data_in[i]),
      .o_h  (lr_d_H_in[i])
    );
  end

endmodule

// File: tb/tb_lr_d_sequencer.sv
// Self-checking bench: random buffer contents and jobs against a row/column
// reference model of reads, skewed parent traffic and write-back.
module tb_lr_d_sequencer;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int CL = 1;  // parent model below is one register stage

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        cfg_rows = '0, cfg_base_g = '0, cfg_base_h = '0, cfg_base_wr = '0;
  logic [15:0]          cfg_leak = '0;
  logic                 pause = 1'b0;
  logic                 busy, done, rd_en;
  logic [AW-1:0]        rd_addr_g, rd_addr_h;
  logic [N-1:0][15:0]   rd_data_g = '0, rd_data_h = '0;
  logic [N-1:0]         lr_d_valid_in;
  logic [N-1:0][15:0]   lr_d_data_in, lr_d_H_in;
  logic [15:0]          lr_leak_factor_out;
  logic [N-1:0]         lr_d_valid_out;
  logic [N-1:0][15:0]   lr_d_data_out;
  logic [N-1:0]         wr_en;
  logic [N-1:0][AW-1:0] wr_addr;
  logic [N-1:0][15:0]   wr_data;

  lr_d_sequencer #(.N(N), .ADDR_W(AW), .CHILD_LAT(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_base_g(cfg_base_g),
    .cfg_base_h(cfg_base_h), .cfg_base_wr(cfg_base_wr), .cfg_leak(cfg_leak), .pause(pause),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr_g(rd_addr_g), .rd_addr_h(rd_addr_h),
    .rd_data_g(rd_data_g), .rd_data_h(rd_data_h), .lr_d_valid_in(lr_d_valid_in),
    .lr_d_data_in(lr_d_data_in), .lr_d_H_in(lr_d_H_in), .lr_leak_factor_out(lr_leak_factor_out),
    .lr_d_valid_out(lr_d_valid_out), .lr_d_data_out(lr_d_data_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [15:0] gmem [256][N];
  logic [15:0] hmem [256][N];

  function automatic logic [15:0] lrd(input logic [15:0] g, input logic [15:0] h,
                                      input logic [15:0] lk);
    logic signed [31:0] p;
    if ($signed(h) > 0) return g;
    p = 32'($signed(g)) * 32'($signed(lk));
    return p[23:8];
  endfunction

  // Buffer read port: one cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < N; i++) begin
        rd_data_g[i] <= gmem[rd_addr_g][i];
        rd_data_h[i] <= hmem[rd_addr_h][i];
      end
    end
  end

  // Parent datapath model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_d_valid_out <= '0;
      lr_d_data_out  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        lr_d_valid_out[i] <= lr_d_valid_in[i];
        lr_d_data_out[i]  <= lrd(lr_d_data_in[i], lr_d_H_in[i], lr_leak_factor_out);
      end
    end
  end

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, start_cyc = 0, done_n = 0, done_c = 0, busy_n = 0, leak_bad = 0;
  logic [15:0] job_leak = '0;
  int          rdg_q[$], rdh_q[$], rdc_q[$];
  int          wcol_q[$], wadr_q[$], wcyc_q[$];
  logic [15:0] wdat_q[$];

  // Observation on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (start && !busy) start_cyc = cyc;
    if (rd_en) begin
      rdg_q.push_back(int'(rd_addr_g));
      rdh_q.push_back(int'(rd_addr_h));
      rdc_q.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (wr_en[i]) begin
        wcol_q.push_back(i);
        wadr_q.push_back(int'(wr_addr[i]));
        wdat_q.push_back(wr_data[i]);
        wcyc_q.push_back(cyc);
      end
    end
    if (done) begin
      done_n++;
      done_c = cyc;
    end
    if (busy) begin
      busy_n++;
      if (lr_leak_factor_out !== job_leak) leak_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_chk(input string when);
    chk({when, "_busy"}, 64'(busy), 64'd0);
    chk({when, "_done"}, 64'(done), 64'd0);
    chk({when, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({when, "_rd_addr"}, 64'({rd_addr_g, rd_addr_h}), 64'd0);
    chk({when, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({when, "_wr_addr_data"}, 64'({wr_addr, wr_data}), 64'd0);
    chk({when, "_valid_in"}, 64'(lr_d_valid_in), 64'd0);
    chk({when, "_data_h_in"}, 64'({lr_d_data_in, lr_d_H_in}), 64'd0);
    chk({when, "_leak_out"}, 64'(lr_leak_factor_out), 64'd0);
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause during issue cycles 2 and 3.
  task automatic run_job(input int rows, input int bg, input int bh, input int bw,
                         input logic [15:0] leak, input int pmode, input bit dup,
                         input int rst_at, input bit now);
    int kc [N];
    int exp_done, col, k;
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < N; i++) begin
        gmem[a][i] = 16'($urandom);
        hmem[a][i] = 16'($urandom);
      end
    rdg_q.delete(); rdh_q.delete(); rdc_q.delete();
    wcol_q.delete(); wadr_q.delete(); wdat_q.delete(); wcyc_q.delete();
    done_n = 0; busy_n = 0; leak_bad = 0; job_leak = leak;
    for (int i = 0; i < N; i++) kc[i] = 0;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; cfg_rows = AW'(rows); cfg_base_g = AW'(bg); cfg_base_h = AW'(bh);
    cfg_base_wr = AW'(bw); cfg_leak = leak;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done_n != 0) break;
      case (pmode)
        1:       pause = 1'($urandom_range(0, 1));
        2:       pause = (c == 2) || (c == 3);
        default: pause = 1'b0;
      endcase
      if (dup && c == 1) begin
        start = 1'b1; cfg_rows = AW'(5); cfg_leak = ~leak;
      end else begin
        start = 1'b0;
      end
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1 zero_chk("rst_mid");
        pause = 1'b0; start = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("rd_count", 64'(rdc_q.size()), 64'(rows));
    for (int r = 0; r < rows && r < rdc_q.size(); r++) begin
      chk($sformatf("rd_addr_g_r%0d", r), 64'(rdg_q[r]), 64'((bg + r) % 256));
      chk($sformatf("rd_addr_h_r%0d", r), 64'(rdh_q[r]), 64'((bh + r) % 256));
    end
    if (rows > 0 && pmode != 1 && rdc_q.size() > 0)
      chk("first_rd_cycle", 64'(rdc_q[0]), 64'(start_cyc + 1));
    if (rows == 0) exp_done = start_cyc + 1;
    else if (pmode == 1) exp_done = (rdc_q.size() > 0) ? rdc_q[rdc_q.size()-1] + N + CL + 1 : -1;
    else exp_done = start_cyc + 1 + rows + N + CL + ((pmode == 2) ? 2 : 0);
    chk("done_count", 64'(done_n), 64'd1);
    chk("done_cycle", 64'(done_c), 64'(exp_done));
    chk("busy_cycles", 64'(busy_n), 64'(done_c - start_cyc - 1));
    chk("leak_stable", 64'(leak_bad), 64'd0);
    chk("leak_out", 64'(lr_leak_factor_out), 64'(leak));
    for (int j = 0; j < wcol_q.size(); j++) begin
      col = wcol_q[j];
      k = kc[col];
      chk($sformatf("wr_addr_c%0d_k%0d", col, k), 64'(wadr_q[j]), 64'((bw + k) % 256));
      chk($sformatf("wr_data_c%0d_k%0d", col, k), 64'(wdat_q[j]),
          64'(lrd(gmem[(bg + k) % 256][col], hmem[(bh + k) % 256][col], leak)));
      if (k < rdc_q.size())
        chk($sformatf("wr_cycle_c%0d_k%0d", col, k), 64'(wcyc_q[j]), 64'(rdc_q[k] + 1 + col + CL));
      kc[col]++;
    end
    for (int i = 0; i < N; i++) chk($sformatf("wr_count_c%0d", i), 64'(kc[i]), 64'(rows));
  endtask

  initial begin
    #2 zero_chk("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_job(3, 0, 8, 16, 16'h0040, 0, 1'b0, -1, 1'b0);
    run_job(0, 5, 6, 7, 16'h0123, 0, 1'b0, -1, 1'b0);
    run_job(4, 30, 40, 50, 16'hFFC0, 2, 1'b0, -1, 1'b0);

    run_job(4, 10, 20, 100, 16'h0080, 0, 1'b0, 5, 1'b0);
    @(posedge clk);
    #1 zero_chk("rst_hold");
    rst = 1'b0;
    run_job(1, 200, 210, 220, 16'h0011, 0, 1'b0, -1, 1'b1);

    run_job(2, 250, 254, 255, 16'h0100, 0, 1'b0, -1, 1'b0);
    run_job(3, 1, 2, 3, 16'h0020, 0, 1'b1, -1, 1'b0);

    for (int t = 0; t < 6; t++)
      run_job($urandom_range(1, 8), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), 16'($urandom), t % 2, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
